// File: rtl/move_rep_pkg.sv
// ---------------------------------------------------------------------------
// move_pkg : command, size and state encodings for move_rep (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

package move_pkg;

  typedef enum logic [1:0] {
    MODE_MOVE  = 2'b00,
    MODE_SWAP  = 2'b01,
    MODE_STORE = 2'b10,
    MODE_ILL   = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'b00,
    SZ_WORD  = 2'b01,
    SZ_DWORD = 2'b10,
    SZ_ILL   = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_READ    = 3'd1,
    ST_WAIT_RD = 3'd2,
    ST_WRITE   = 3'd3,
    ST_STEP    = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    case (sz)
      SZ_BYTE:  return 3'd1;
      SZ_WORD:  return 3'd2;
      SZ_DWORD: return 3'd4;
      default:  return 3'd0;
    endcase
  endfunction

  function automatic logic [3:0] be_for_size(input logic [1:0] sz);
    case (sz)
      SZ_BYTE:  return 4'b0001;
      SZ_WORD:  return 4'b0011;
      SZ_DWORD: return 4'b1111;
      default:  return 4'b0000;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/move_rep_if.sv
// ---------------------------------------------------------------------------
// move_rep_if : command, memory-request and result bundle (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

interface move_rep_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
) ();

  logic                  start_valid;
  logic                  start_ready;
  logic [1:0]            mode;
  logic [1:0]            size;
  logic                  dir;
  logic                  rep;
  logic [CNT_W-1:0]      count;
  logic [ADDR_W-1:0]     src_addr;
  logic [ADDR_W-1:0]     dst_addr;
  logic [DATA_W-1:0]     opnd0_r;
  logic [DATA_W-1:0]     opnd1_r;

  logic                  rd_valid;
  logic                  rd_ready;
  logic [ADDR_W-1:0]     rd_addr;
  logic                  rd_resp_valid;
  logic [DATA_W-1:0]     rd_data;

  logic                  wr_valid;
  logic                  wr_ready;
  logic [ADDR_W-1:0]     wr_addr;
  logic [DATA_W-1:0]     wr_data;
  logic [DATA_W/8-1:0]   wr_be;

  logic                  done;
  logic                  err;
  logic [ADDR_W-1:0]     src_out;
  logic [ADDR_W-1:0]     dst_out;
  logic [CNT_W-1:0]      cnt_out;
  logic [DATA_W-1:0]     opnd0_w;
  logic [DATA_W-1:0]     opnd1_w;

  // engine side
  modport slave (
    input  start_valid, mode, size, dir, rep, count, src_addr, dst_addr, opnd0_r, opnd1_r,
    input  rd_ready, rd_resp_valid, rd_data, wr_ready,
    output start_ready, rd_valid, rd_addr, wr_valid, wr_addr, wr_data, wr_be,
    output done, err, src_out, dst_out, cnt_out, opnd0_w, opnd1_w
  );

  // command issuer / memory side
  modport master (
    output start_valid, mode, size, dir, rep, count, src_addr, dst_addr, opnd0_r, opnd1_r,
    output rd_ready, rd_resp_valid, rd_data, wr_ready,
    input  start_ready, rd_valid, rd_addr, wr_valid, wr_addr, wr_data, wr_be,
    input  done, err, src_out, dst_out, cnt_out, opnd0_w, opnd1_w
  );

endinterface

`default_nettype wire

// File: rtl/move_rep_addr_step.sv
// ---------------------------------------------------------------------------
// addr_step : address +/- element size, wrapping modulo 2^ADDR_W (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module addr_step
  import move_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [1:0]        size,
  input  logic              dir,
  output logic [ADDR_W-1:0] addr_next
);

  logic [ADDR_W-1:0] delta;

  assign delta     = ADDR_W'(size_bytes(size));
  assign addr_next = dir ? (addr - delta) : (addr + delta);

endmodule

`default_nettype wire

// File: rtl/move_rep.sv
// ---------------------------------------------------------------------------
// move_rep : multi-cycle MOVE / STORE / SWAP engine with REP count (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module move_rep
  import move_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic      clk,
  input  logic      rst,
  move_rep_if.slave bus
);

  localparam int BE_W = DATA_W / 8;

  state_e              state_q, state_d;
  mode_e               mode_q,  mode_d;
  logic [1:0]          size_q,  size_d;
  logic                dir_q,   dir_d;
  logic                rep_q,   rep_d;
  logic                err_q,   err_d;
  logic [ADDR_W-1:0]   src_q,   src_d;
  logic [ADDR_W-1:0]   dst_q,   dst_d;
  logic [CNT_W-1:0]    cnt_q,   cnt_d;
  logic [DATA_W-1:0]   op0_q,   op0_d;
  logic [DATA_W-1:0]   op1_q,   op1_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic [ADDR_W-1:0]   src_next;
  logic [ADDR_W-1:0]   dst_next;
  logic                wr_valid_w;

  addr_step #(.ADDR_W(ADDR_W)) u_src_step (
    .addr      (src_q),
    .size      (size_q),
    .dir       (dir_q),
    .addr_next (src_next)
  );

  addr_step #(.ADDR_W(ADDR_W)) u_dst_step (
    .addr      (dst_q),
    .size      (size_q),
    .dir       (dir_q),
    .addr_next (dst_next)
  );

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    size_d  = size_q;
    dir_d   = dir_q;
    rep_d   = rep_q;
    err_d   = err_q;
    src_d   = src_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    op0_d   = op0_q;
    op1_d   = op1_q;
    rdata_d = rdata_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start_valid) begin
          mode_d = mode_e'(bus.mode);
          size_d = bus.size;
          dir_d  = bus.dir;
          rep_d  = bus.rep;
          err_d  = 1'b0;
          src_d  = bus.src_addr;
          dst_d  = bus.dst_addr;
          cnt_d  = bus.count;
          op0_d  = bus.opnd0_r;
          op1_d  = bus.opnd1_r;
          if (bus.mode == MODE_ILL || bus.size == SZ_ILL) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else if (bus.mode == MODE_SWAP) begin
            op0_d   = bus.opnd1_r;
            op1_d   = bus.opnd0_r;
            state_d = ST_DONE;
          end else if (bus.rep && bus.count == '0) begin
            state_d = ST_DONE;
          end else if (bus.mode == MODE_MOVE) begin
            state_d = ST_READ;
          end else begin
            state_d = ST_WRITE;
          end
        end
      end
      ST_READ: begin
        if (bus.rd_ready) state_d = ST_WAIT_RD;
      end
      ST_WAIT_RD: begin
        if (bus.rd_resp_valid) begin
          rdata_d = bus.rd_data;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (bus.wr_ready) state_d = ST_STEP;
      end
      ST_STEP: begin
        dst_d = dst_next;
        if (mode_q == MODE_MOVE) src_d = src_next;
        if (rep_q) cnt_d = cnt_q - CNT_W'(1);
        // cnt_q == 1 here means the decrement just reached zero
        if (!rep_q || cnt_q == CNT_W'(1)) begin
          state_d = ST_DONE;
        end else if (mode_q == MODE_MOVE) begin
          state_d = ST_READ;
        end else begin
          state_d = ST_WRITE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_MOVE;
      size_q  <= '0;
      dir_q   <= 1'b0;
      rep_q   <= 1'b0;
      err_q   <= 1'b0;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      op0_q   <= '0;
      op1_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      size_q  <= size_d;
      dir_q   <= dir_d;
      rep_q   <= rep_d;
      err_q   <= err_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      op0_q   <= op0_d;
      op1_q   <= op1_d;
      rdata_q <= rdata_d;
    end
  end

  assign wr_valid_w      = (state_q == ST_WRITE);

  assign bus.start_ready = (state_q == ST_IDLE);
  assign bus.rd_valid    = (state_q == ST_READ);
  assign bus.rd_addr     = src_q;
  assign bus.wr_valid    = wr_valid_w;
  assign bus.wr_addr     = dst_q;
  // STORE fill value lives in op0_q, which SWAP is the only mode to overwrite
  assign bus.wr_data     = (mode_q == MODE_STORE) ? op0_q : rdata_q;
  assign bus.wr_be       = wr_valid_w ? BE_W'(be_for_size(size_q)) : '0;

  assign bus.done        = (state_q == ST_DONE);
  assign bus.err         = (state_q == ST_DONE) && err_q;
  assign bus.src_out     = src_q;
  assign bus.dst_out     = dst_q;
  assign bus.cnt_out     = cnt_q;
  assign bus.opnd0_w     = op0_q;
  assign bus.opnd1_w     = op1_q;

endmodule

`default_nettype wire

// File: tb/tb_move_rep.sv
// ---------------------------------------------------------------------------
// tb_move_rep : directed bench for move_rep with a small memory responder (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module tb_move_rep;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  move_rep_if #(.ADDR_W(32), .DATA_W(32), .CNT_W(32)) bus ();

  move_rep #(.ADDR_W(32), .DATA_W(32), .CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // memory responder state
  int          rd_stall, wr_stall;
  int          rd_vcnt, wr_vcnt;
  logic        rd_pending;
  logic [31:0] rd_pend_addr;
  logic        rd_held, wr_held;
  logic [31:0] rd_held_addr, wr_held_addr, wr_held_data;
  logic [3:0]  wr_held_be;
  logic [31:0] rd_log[$];
  logic [31:0] wa_log[$];
  logic [31:0] wd_log[$];
  logic [3:0]  wb_log[$];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  // Advance to the next falling edge and drive memory-side inputs for the coming cycle.
  task automatic tick();
    @(negedge clk);
    if (rd_pending) begin
      bus.rd_resp_valid = 1'b1;
      bus.rd_data       = memf(rd_pend_addr);
      rd_pending        = 1'b0;
    end else begin
      bus.rd_resp_valid = 1'b0;
      bus.rd_data       = '0;
    end
    if (bus.rd_valid) begin
      rd_vcnt++;
      if (rd_held) check("rd_addr_hold", bus.rd_addr, rd_held_addr);
      if (rd_stall > 0) begin
        rd_stall--;
        bus.rd_ready = 1'b0;
        rd_held      = 1'b1;
        rd_held_addr = bus.rd_addr;
      end else begin
        bus.rd_ready = 1'b1;
        rd_held      = 1'b0;
        rd_pending   = 1'b1;
        rd_pend_addr = bus.rd_addr;
        rd_log.push_back(bus.rd_addr);
      end
    end else begin
      bus.rd_ready = 1'b0;
      rd_held      = 1'b0;
    end
    if (bus.wr_valid) begin
      wr_vcnt++;
      if (wr_held) begin
        check("wr_addr_hold", bus.wr_addr, wr_held_addr);
        check("wr_data_hold", bus.wr_data, wr_held_data);
        check("wr_be_hold", bus.wr_be, wr_held_be);
      end
      if (wr_stall > 0) begin
        wr_stall--;
        bus.wr_ready = 1'b0;
        wr_held      = 1'b1;
        wr_held_addr = bus.wr_addr;
        wr_held_data = bus.wr_data;
        wr_held_be   = bus.wr_be;
      end else begin
        bus.wr_ready = 1'b1;
        wr_held      = 1'b0;
        wa_log.push_back(bus.wr_addr);
        wd_log.push_back(bus.wr_data);
        wb_log.push_back(bus.wr_be);
      end
    end else begin
      bus.wr_ready = 1'b0;
      wr_held      = 1'b0;
    end
  endtask

  task automatic drive_cmd(input logic [1:0] mode, input logic [1:0] size, input logic dir,
                           input logic rep, input logic [31:0] count, input logic [31:0] src,
                           input logic [31:0] dst, input logic [31:0] o0, input logic [31:0] o1);
    tick();
    rd_log.delete(); wa_log.delete(); wd_log.delete(); wb_log.delete();
    rd_vcnt = 0; wr_vcnt = 0;
    bus.start_valid = 1'b1;
    bus.mode = mode; bus.size = size; bus.dir = dir; bus.rep = rep;
    bus.count = count; bus.src_addr = src; bus.dst_addr = dst;
    bus.opnd0_r = o0; bus.opnd1_r = o1;
    @(posedge clk);
    tick();
    bus.start_valid = 1'b0;
  endtask

  // Issue a command; returns the cycle (accept = 0) of done and the err seen with it.
  task automatic run_cmd(input string tag, input logic [1:0] mode, input logic [1:0] size,
                         input logic dir, input logic rep, input logic [31:0] count,
                         input logic [31:0] src, input logic [31:0] dst,
                         input logic [31:0] o0, input logic [31:0] o1,
                         output int done_cyc, output logic err_at_done);
    int cyc;
    drive_cmd(mode, size, dir, rep, count, src, dst, o0, o1);
    cyc = 1;
    while (!bus.done && cyc < 300) begin
      tick();
      cyc++;
    end
    if (!bus.done) begin
      check({tag, "_timeout"}, 64'd0, 64'd1);
      done_cyc = -1;
      err_at_done = 1'bx;
    end else begin
      done_cyc = cyc;
      err_at_done = bus.err;
      tick();
      check({tag, "_done_pulse"}, bus.done, 1'b0);
    end
  endtask

  int   dc;
  logic er;
  logic saw_done;

  initial begin
    rst = 1'b1;
    bus.start_valid = 1'b0; bus.mode = '0; bus.size = '0; bus.dir = 1'b0; bus.rep = 1'b0;
    bus.count = '0; bus.src_addr = '0; bus.dst_addr = '0; bus.opnd0_r = '0; bus.opnd1_r = '0;
    bus.rd_ready = 1'b0; bus.rd_resp_valid = 1'b0; bus.rd_data = '0; bus.wr_ready = 1'b0;
    rd_stall = 0; wr_stall = 0; rd_vcnt = 0; wr_vcnt = 0;
    rd_pending = 1'b0; rd_pend_addr = '0; rd_held = 1'b0; wr_held = 1'b0;
    rd_held_addr = '0; wr_held_addr = '0; wr_held_data = '0; wr_held_be = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // reset state
    check("rst_start_ready", bus.start_ready, 1'b1);
    check("rst_rd_valid", bus.rd_valid, 1'b0);
    check("rst_wr_valid", bus.wr_valid, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_err", bus.err, 1'b0);
    check("rst_src_out", bus.src_out, 32'h0);
    check("rst_dst_out", bus.dst_out, 32'h0);
    check("rst_cnt_out", bus.cnt_out, 32'h0);
    check("rst_opnd0_w", bus.opnd0_w, 32'h0);
    check("rst_wr_be", bus.wr_be, 4'h0);

    // SWAP
    run_cmd("swap", 2'b01, 2'b10, 1'b0, 1'b0, 32'd9, 32'h100, 32'h200,
            32'h1122_3344, 32'hAABB_CCDD, dc, er);
    check("swap_done_cyc", dc, 1);
    check("swap_err", er, 1'b0);
    check("swap_opnd0_w", bus.opnd0_w, 32'hAABB_CCDD);
    check("swap_opnd1_w", bus.opnd1_w, 32'h1122_3344);
    check("swap_src_out", bus.src_out, 32'h100);
    check("swap_cnt_out", bus.cnt_out, 32'd9);
    check("swap_no_req", rd_vcnt + wr_vcnt, 0);

    // MOVE dword x3, zero-wait
    run_cmd("movd", 2'b00, 2'b10, 1'b0, 1'b1, 32'd3, 32'h1000, 32'h2000,
            32'h0, 32'h0, dc, er);
    check("movd_done_cyc", dc, 13);
    check("movd_err", er, 1'b0);
    check("movd_nrd", rd_log.size(), 3);
    check("movd_nwr", wa_log.size(), 3);
    for (int i = 0; i < 3 && i < rd_log.size() && i < wa_log.size(); i++) begin
      check("movd_rd_addr", rd_log[i], 32'h1000 + 32'(4 * i));
      check("movd_wr_addr", wa_log[i], 32'h2000 + 32'(4 * i));
      check("movd_wr_data", wd_log[i], memf(32'h1000 + 32'(4 * i)));
      check("movd_wr_be", wb_log[i], 4'b1111);
    end
    check("movd_src_out", bus.src_out, 32'h100C);
    check("movd_dst_out", bus.dst_out, 32'h200C);
    check("movd_cnt_out", bus.cnt_out, 32'd0);

    // STORE byte x2, decrementing through zero
    run_cmd("stob", 2'b10, 2'b00, 1'b1, 1'b1, 32'd2, 32'h3000, 32'h0000_0001,
            32'h5A, 32'h0, dc, er);
    check("stob_done_cyc", dc, 5);
    check("stob_nwr", wa_log.size(), 2);
    check("stob_nrd", rd_vcnt, 0);
    for (int i = 0; i < 2 && i < wa_log.size(); i++) begin
      check("stob_wr_addr", wa_log[i], 32'(1 - i));
      check("stob_wr_data", wd_log[i], 32'h5A);
      check("stob_wr_be", wb_log[i], 4'b0001);
    end
    check("stob_dst_out", bus.dst_out, 32'hFFFF_FFFF);
    check("stob_src_out", bus.src_out, 32'h3000);
    check("stob_cnt_out", bus.cnt_out, 32'd0);

    // REP with count 0
    run_cmd("rep0", 2'b00, 2'b01, 1'b0, 1'b1, 32'd0, 32'h4000, 32'h5000,
            32'h77, 32'h88, dc, er);
    check("rep0_done_cyc", dc, 1);
    check("rep0_no_req", rd_vcnt + wr_vcnt, 0);
    check("rep0_src_out", bus.src_out, 32'h4000);
    check("rep0_dst_out", bus.dst_out, 32'h5000);
    check("rep0_cnt_out", bus.cnt_out, 32'd0);

    // illegal mode
    run_cmd("ill", 2'b11, 2'b10, 1'b0, 1'b1, 32'd5, 32'hA000, 32'hB000,
            32'h1234, 32'h5678, dc, er);
    check("ill_done_cyc", dc, 1);
    check("ill_err", er, 1'b1);
    check("ill_src_out", bus.src_out, 32'hA000);
    check("ill_cnt_out", bus.cnt_out, 32'd5);
    check("ill_opnd0_w", bus.opnd0_w, 32'h1234);
    check("ill_no_req", rd_vcnt + wr_vcnt, 0);

    // MOVE word, rep=0, with stalls on both request ports
    rd_stall = 3;
    wr_stall = 2;
    run_cmd("movw", 2'b00, 2'b01, 1'b0, 1'b0, 32'd7, 32'h6000, 32'h7000,
            32'h0, 32'h0, dc, er);
    check("movw_done_cyc", dc, 10);
    check("movw_nrd", rd_log.size(), 1);
    check("movw_nwr", wa_log.size(), 1);
    if (wa_log.size() > 0) begin
      check("movw_wr_addr", wa_log[0], 32'h7000);
      check("movw_wr_data", wd_log[0], memf(32'h6000));
      check("movw_wr_be", wb_log[0], 4'b0011);
    end
    check("movw_src_out", bus.src_out, 32'h6002);
    check("movw_dst_out", bus.dst_out, 32'h7002);
    check("movw_cnt_out", bus.cnt_out, 32'd7);

    // reset during WAIT_RD
    drive_cmd(2'b00, 2'b10, 1'b0, 1'b1, 32'd4, 32'h8000, 32'h9000, 32'h0, 32'h0);
    tick();
    check("rstop_in_wait", bus.rd_valid | bus.wr_valid | bus.start_ready, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstop_idle", bus.start_ready, 1'b1);
    check("rstop_done", bus.done, 1'b0);
    check("rstop_rd_valid", bus.rd_valid, 1'b0);
    saw_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.done) saw_done = 1'b1;
    end
    check("rstop_no_done", saw_done, 1'b0);
    check("rstop_no_wr", wr_vcnt, 0);

    run_cmd("swap2", 2'b01, 2'b00, 1'b0, 1'b0, 32'd0, 32'h0, 32'h0,
            32'h0BAD_F00D, 32'h1234_5678, dc, er);
    check("swap2_done_cyc", dc, 1);
    check("swap2_opnd0_w", bus.opnd0_w, 32'h1234_5678);
    check("swap2_opnd1_w", bus.opnd1_w, 32'h0BAD_F00D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
